wavelet_coef_packer: RTL and testbench
======================================

WAVELET_COEF_PACKER -- requirements
Module: wavelet_coef_packer

Interface
REQ-001 Parameter QSHIFT, default 2, right-shift applied to H magnitude for quantization (0..7).
REQ-002 Parameter FIFO_DEPTH, default 4, input pair FIFO depth (power of two, >=2).
REQ-003 Parameter MAX_RUN, default 15, zero-H run length forcing a RUN token (1..255).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  coefficient pair offered.
REQ-007 in_ready  out  1  pair accepted when in_valid && in_ready at rising clk.
REQ-008 in_l  in  8  unsigned low-band coefficient from lifting stage.
REQ-009 in_h  in  8  two's-complement high-band coefficient from lifting stage.
REQ-010 flush  in  1  single-cycle pulse, end of line; forces emission of pending run.
REQ-011 out_valid  out  1  output byte valid.
REQ-012 out_ready  in  1  downstream accepts byte when out_valid && out_ready.
REQ-013 out_data  out  8  output byte.
REQ-014 out_tag  out  2  00 = L byte, 01 = H byte, 10 = RUN token, 11 unused.
REQ-015 busy  out  1  high while FIFO non-empty, FSM not IDLE, or flush pending.

Function
REQ-016 in_ready SHALL equal "FIFO not full"; a pop in the same cycle SHALL NOT raise in_ready in that cycle.
REQ-017 Accepted pair SHALL be written to FIFO at that edge; FSM SHALL pop it no earlier than next edge, first output byte out_valid no earlier than 2 cycles after acceptance.
REQ-018 Quantization: mag = |in_h| (9-bit, 0x80 -> 128); qmag = mag >> QSHIFT; qh = sign-restored qmag as 8-bit two's complement; qh = 0 when mag < 2^QSHIFT; L passes unchanged.
REQ-019 FSM states IDLE, EMIT_L, EMIT_RUN, EMIT_H.
REQ-020 IDLE: FIFO non-empty -> pop into L/qh registers, go EMIT_L; else flush pending and run>0 -> EMIT_RUN; else flush pending cleared, stay IDLE.
REQ-021 EMIT_L: drive tag 00, data L; on handshake: qh!=0 and run>0 -> EMIT_RUN with H pending; qh!=0 and run=0 -> EMIT_H; qh=0 -> run+1, go EMIT_RUN if run+1 = MAX_RUN else IDLE.
REQ-022 EMIT_RUN: drive tag 10, data run count; on handshake clear run, go EMIT_H if H pending else IDLE.
REQ-023 EMIT_H: drive tag 01, data qh; on handshake go IDLE.
REQ-024 out_data/out_tag SHALL remain stable while out_valid && !out_ready; out_valid SHALL NOT drop without handshake.
REQ-025 flush SHALL set flush pending; queued pairs are processed first; pending run emitted only once FIFO empty; flush while run=0 emits nothing.
REQ-026 flush coinciding with a pair acceptance SHALL cover that pair.
REQ-027 Run counter SHALL never exceed MAX_RUN and never wrap.

Reset
REQ-028 rst SHALL immediately force: FIFO empty, state IDLE, run 0, flush pending 0, out_valid 0, out_data 0, out_tag 00, in_ready 0 while rst high, busy 0.
REQ-029 in_ready SHALL assert on the first rising clk after rst deasserts; reset mid-packet discards all buffered pairs and partial runs.

Configuration
REQ-030 Macro ZERO_SUPPRESS_EN defined: zero qh suppressed and RUN tokens generated as above.
REQ-031 Macro ZERO_SUPPRESS_EN undefined: every pair emits L then H (including qh=0), tag 10 never produced, run logic absent, flush only affects busy.

Verification
REQ-032 Pair L=0x22, H=0x44, out_ready=1 -> (00,0x22) then (01,0x11).
REQ-033 Three pairs H=0x03 then pair L=0x50 H=0xF0 -> three L bytes, (00,0x50), (10,0x03), (01,0xFC).
REQ-034 Fifteen pairs H=0x00 -> RUN token (10,0x0F) immediately after 15th L byte; run back to 0.
REQ-035 out_ready=0, six pairs offered -> in_ready low after 5th acceptance (4 FIFO + 1 in FSM), out_data held at first L; release out_ready -> all bytes in order.
REQ-036 Two zero-H pairs then flush pulse, FIFO empty -> (10,0x02) emitted, busy falls the cycle after handshake.
REQ-037 rst asserted during EMIT_H with 3 pairs queued -> out_valid 0 without clk edge; after release no stale bytes, busy 0.

Source files
------------

// File: rtl/wavelet_coef_packer_if.sv
// Byte-stream bundle for the wavelet coefficient packer:
// pair input side and tagged byte output side.
interface wavelet_coef_packer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_l;
    logic [7:0] in_h;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_tag;

    modport master (
        output in_valid,
        output in_l,
        output in_h,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_tag
    );

    modport slave (
        input  in_valid,
        input  in_l,
        input  in_h,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_tag
    );
endinterface

// File: rtl/wavelet_coef_packer.sv
// Wavelet L/H pair quantizer and byte packer with pair FIFO.
// Define ZERO_SUPPRESS_EN for zero-H suppression with RUN tokens.
module wavelet_coef_packer #(
    parameter int QSHIFT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RUN    = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    output logic busy,
    wavelet_coef_packer_if.slave bus
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];
    localparam logic [7:0] MAX_C = MAX_RUN[7:0];

    typedef enum logic [1:0] {
        IDLE,
        EMIT_L,
        EMIT_RUN,
        EMIT_H
    } state_t;

    state_t state, state_n;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;
    logic          empty, full;
    logic          push, pop, hs;
    logic          rdy_en;
    logic          flush_pend, flush_clr;

    logic [7:0] l_q, qh_q;
    logic [7:0] head_l, head_h, qh_head;
    logic [8:0] mag, qmag, qsgn;
    logic       unused_qsgn;

`ifdef ZERO_SUPPRESS_EN
    logic [7:0] run_q;
    logic       h_pend;
    logic       run_inc, run_clr;
    logic       h_set, h_clr;
`endif

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // in_ready only looks at registered state, so a same-cycle
    // pop never opens the FIFO early.
    assign bus.in_ready = rdy_en && !full;
    assign push = bus.in_valid && bus.in_ready;
    assign hs   = bus.out_valid && bus.out_ready;

    assign head_l = mem[rptr][15:8];
    assign head_h = mem[rptr][7:0];

    assign mag  = head_h[7] ? (9'd0 - {1'b1, head_h})
                            : {1'b0, head_h};
    assign qmag = mag >> QSHIFT;
    assign qsgn = head_h[7] ? (9'd0 - qmag) : qmag;
    assign qh_head     = qsgn[7:0];
    assign unused_qsgn = qsgn[8];

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {bus.in_l, bus.in_h};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        flush_clr = 1'b0;
`ifdef ZERO_SUPPRESS_EN
        run_inc = 1'b0;
        run_clr = 1'b0;
        h_set   = 1'b0;
        h_clr   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = EMIT_L;
                end
`ifdef ZERO_SUPPRESS_EN
                else if (flush_pend && run_q != 8'd0)
                    state_n = EMIT_RUN;
`endif
                else
                    flush_clr = 1'b1;
            end
            EMIT_L: begin
                if (hs) begin
`ifdef ZERO_SUPPRESS_EN
                    if (qh_q != 8'd0) begin
                        if (run_q != 8'd0) begin
                            state_n = EMIT_RUN;
                            h_set   = 1'b1;
                        end else begin
                            state_n = EMIT_H;
                        end
                    end else begin
                        run_inc = 1'b1;
                        if (run_q + 8'd1 == MAX_C)
                            state_n = EMIT_RUN;
                        else
                            state_n = IDLE;
                    end
`else
                    state_n = EMIT_H;
`endif
                end
            end
            EMIT_RUN: begin
`ifdef ZERO_SUPPRESS_EN
                if (hs) begin
                    run_clr   = 1'b1;
                    h_clr     = 1'b1;
                    state_n   = h_pend ? EMIT_H : IDLE;
                    flush_clr = !h_pend && empty;
                end
`else
                state_n = IDLE;
`endif
            end
            EMIT_H: begin
                if (hs)
                    state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = 8'd0;
        bus.out_tag   = 2'b00;
        unique case (state)
            IDLE: begin
                bus.out_valid = 1'b0;
            end
            EMIT_L: begin
                bus.out_valid = 1'b1;
                bus.out_data  = l_q;
                bus.out_tag   = 2'b00;
            end
            EMIT_RUN: begin
                bus.out_valid = 1'b1;
`ifdef ZERO_SUPPRESS_EN
                bus.out_data  = run_q;
`endif
                bus.out_tag   = 2'b10;
            end
            EMIT_H: begin
                bus.out_valid = 1'b1;
                bus.out_data  = qh_q;
                bus.out_tag   = 2'b01;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            l_q        <= 8'd0;
            qh_q       <= 8'd0;
            flush_pend <= 1'b0;
        end else begin
            state <= state_n;
            if (pop) begin
                l_q  <= head_l;
                qh_q <= qh_head;
            end
            // A new flush pulse wins over a same-cycle clear.
            if (flush)
                flush_pend <= 1'b1;
            else if (flush_clr)
                flush_pend <= 1'b0;
        end
    end

`ifdef ZERO_SUPPRESS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= 8'd0;
            h_pend <= 1'b0;
        end else begin
            if (run_clr)
                run_q <= 8'd0;
            else if (run_inc)
                run_q <= run_q + 8'd1;
            if (h_set)
                h_pend <= 1'b1;
            else if (h_clr)
                h_pend <= 1'b0;
        end
    end
`endif

    assign busy = !empty || (state != IDLE) || flush_pend;

endmodule

// File: tb/tb_wavelet_coef_packer.sv
// Scoreboard bench for wavelet_coef_packer; expected bytes are
// hand-computed constants, with ZERO_SUPPRESS_EN variants.
module tb_wavelet_coef_packer;

    logic clk;
    logic rst;
    logic flush;
    logic busy;

    wavelet_coef_packer_if bus ();

    wavelet_coef_packer #(
        .QSHIFT    (2),
        .FIFO_DEPTH(4),
        .MAX_RUN   (15)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .busy (busy),
        .bus  (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int accepted = 0;
    logic [15:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic ex(input logic [1:0] tag, input logic [7:0] d);
        exp_q.push_back({6'd0, tag, d});
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got tag %0d data %h expected none",
                         bus.out_tag, bus.out_data);
            end else begin
                chk("out_byte", {6'd0, bus.out_tag, bus.out_data},
                    exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] l, input logic [7:0] h);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_l     = l;
        bus.in_h     = h;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            n++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            accepted++;
        end else begin
            chk("send_timeout", 16'd0, 16'd1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 16'(exp_q.size()), 16'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_l      = 8'd0;
        bus.in_h      = 8'd0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready",  {15'd0, bus.in_ready},  16'd0);
        chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_out_data",  {8'd0, bus.out_data},   16'd0);
        chk("rst_out_tag",   {14'd0, bus.out_tag},   16'd0);
        chk("rst_busy",      {15'd0, busy},          16'd0);
        idle(3);
        rst = 1'b0;
        #1;
        chk("rdy_before_edge", {15'd0, bus.in_ready}, 16'd0);
        @(posedge clk);
        #1;
        chk("rdy_after_edge", {15'd0, bus.in_ready}, 16'd1);

        // basic pair
        ex(2'b00, 8'h22); ex(2'b01, 8'h11);
        send(8'h22, 8'h44);
        wait_drain(50);
        idle(3);

        // small H values quantize to zero
`ifdef ZERO_SUPPRESS_EN
        ex(2'b00, 8'h10); ex(2'b00, 8'h11); ex(2'b00, 8'h12);
        ex(2'b00, 8'h50); ex(2'b10, 8'h03); ex(2'b01, 8'hFC);
`else
        ex(2'b00, 8'h10); ex(2'b01, 8'h00);
        ex(2'b00, 8'h11); ex(2'b01, 8'h00);
        ex(2'b00, 8'h12); ex(2'b01, 8'h00);
        ex(2'b00, 8'h50); ex(2'b01, 8'hFC);
`endif
        send(8'h10, 8'h03);
        send(8'h11, 8'h03);
        send(8'h12, 8'h03);
        send(8'h50, 8'hF0);
        wait_drain(100);
        idle(3);

        // quantization edge values
        ex(2'b00, 8'h01); ex(2'b01, 8'hE0);
        ex(2'b00, 8'h02); ex(2'b01, 8'h1F);
        ex(2'b00, 8'h03); ex(2'b01, 8'hFF);
        send(8'h01, 8'h80);
        send(8'h02, 8'h7F);
        send(8'h03, 8'hFC);
        wait_drain(100);
        idle(3);

        // fifteen zero-H pairs hit MAX_RUN
        for (int i = 0; i < 15; i++) begin
            ex(2'b00, 8'(8'h80 + i));
`ifndef ZERO_SUPPRESS_EN
            ex(2'b01, 8'h00);
`endif
        end
`ifdef ZERO_SUPPRESS_EN
        ex(2'b10, 8'h0F);
`endif
        ex(2'b00, 8'h33); ex(2'b01, 8'h02);
        for (int i = 0; i < 15; i++)
            send(8'(8'h80 + i), 8'h00);
        send(8'h33, 8'h08);
        wait_drain(300);
        idle(3);

        // flush of a pending run
        ex(2'b00, 8'h61);
`ifndef ZERO_SUPPRESS_EN
        ex(2'b01, 8'h00);
`endif
        ex(2'b00, 8'h62);
`ifndef ZERO_SUPPRESS_EN
        ex(2'b01, 8'h00);
`endif
        send(8'h61, 8'h01);
        send(8'h62, 8'h00);
        wait_drain(100);
        pulse_flush();
        chk("flush_busy", {15'd0, busy}, 16'd1);
`ifdef ZERO_SUPPRESS_EN
        ex(2'b10, 8'h02);
        wait_drain(50);
        chk("busy_after_run", {15'd0, busy}, 16'd0);
`else
        idle(1);
        chk("busy_after_flush", {15'd0, busy}, 16'd0);
`endif
        idle(3);

        // flush with no run emits nothing
        pulse_flush();
        chk("flush0_busy", {15'd0, busy}, 16'd1);
        idle(1);
        chk("flush0_idle", {15'd0, busy}, 16'd0);
        idle(5);

        // backpressure: 4 in FIFO + 1 in FSM
        bus.out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            ex(2'b00, 8'(8'hA0 + i));
            ex(2'b01, 8'h08);
        end
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(8'(8'hA0 + i), 8'h20);
            end
        join_none
        idle(12);
        chk("bp_accepted", 16'(accepted), 16'd5);
        chk("bp_in_ready", {15'd0, bus.in_ready}, 16'd0);
        chk("bp_hold_data", {8'd0, bus.out_data}, 16'h00A0);
        chk("bp_hold_tag", {14'd0, bus.out_tag}, 16'd0);
        chk("bp_valid", {15'd0, bus.out_valid}, 16'd1);
        bus.out_ready = 1'b1;
        wait_drain(200);
        chk("bp_all_sent", 16'(accepted), 16'd6);
        idle(3);

        // reset while in EMIT_H with three pairs queued
        bus.out_ready = 1'b0;
        ex(2'b00, 8'h70);
        send(8'h70, 8'h40);
        send(8'h71, 8'h41);
        send(8'h72, 8'h42);
        send(8'h73, 8'h43);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("pre_rst_tag", {14'd0, bus.out_tag}, 16'd1);
        chk("pre_rst_data", {8'd0, bus.out_data}, 16'h0010);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("async_busy", {15'd0, busy}, 16'd0);
        chk("async_in_ready", {15'd0, bus.in_ready}, 16'd0);
        chk("async_tag", {14'd0, bus.out_tag}, 16'd0);
        idle(2);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        idle(20);
        chk("post_rst_busy", {15'd0, busy}, 16'd0);
        chk("post_rst_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("post_rst_q", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
